bist_response_analyzer: RTL and testbench
=========================================

# bist_response_analyzer

- Output-side half of the 1-bit full-adder BIST loop.
- The pattern source drives `a/b/cin` (with fault controls) into `CUT_1bit_full_adder`. This block samples the CUT's `sum/cout` together with the echoed stimulus.
- It checks each response against a built-in golden full-adder model and compacts all responses into a MISR signature.
- At end of session it reports pass/fail, the mismatch count, the first failing pattern index and the final signature.

## Interface
Parameters:
- `MISR_W`, 8, signature width (≥3)
- `MISR_POLY`, 8'h1D, feedback taps XORed in when MSB shifts out
- `MISR_SEED`, 8'h01, signature value loaded at session start
- `N_PATTERNS`, 8, responses per session (1..255)

Ports:
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: reset is synchronous and active-high
- `start` in 1: pulse; begins a session when idle or done
- `resp_valid` in 1: `a, b, cin, sum, cout` valid this cycle
- `a`, `b`, `cin` in 1 each: stimulus applied to the CUT
- `sum`, `cout` in 1 each: CUT response
- `golden_sig` in MISR_W: expected signature; sampled in CHECK
- `busy` out 1: session in progress (RUN or CHECK)
- `done` out 1: session finished, results valid
- `pass` out 1: `err_count==0` and signature match
- `sig_match` out 1: `signature==golden_sig`
- `err_count` out 8: number of mismatching responses, saturating at 255
- `first_err_idx` out 8: pattern index of first mismatch, 8'hFF if none
- `signature` out MISR_W: current/final MISR value

## Operation
- FSM states:
  - IDLE: after reset. `start` moves to RUN.
  - RUN: samples responses. After the N_PATTERNS-th accepted `resp_valid`, moves to CHECK.
  - CHECK: one cycle, then DONE.
  - DONE: holds until `start` returns it to RUN.
- On `start` (IDLE/DONE):
  - `signature`←MISR_SEED, `err_count`←0, `first_err_idx`←8'hFF, pattern index←0
  - `done`, `pass`, `sig_match`←0
- Each `resp_valid` in RUN:
  - Golden model: `exp_sum=a^b^cin`, `exp_cout=ab|acin|bcin`.
  - Mismatch = (`sum≠exp_sum`) or (`cout≠exp_cout`). A dual-bit error counts once.
  - Mismatch increments `err_count` (saturating at 255).
  - If `first_err_idx==8'hFF`, the current pattern index is stored in `first_err_idx`.
  - MISR step: `next = {sig[W-2:0],0} ^ (sig[W-1] ? MISR_POLY : 0) ^ {0…,cout,sum}`. `sum` lands in bit0, `cout` in bit1.
  - Pattern index increments.
- CHECK: `sig_match`←(`signature==golden_sig`); `pass`←`sig_match && err_count==0`; `done`←1 on the following edge.
- Ignored inputs:
  - `resp_valid` in IDLE, CHECK or DONE.
  - `start` in RUN or CHECK. A session cannot be restarted mid-run; use `rst`.
- X/Z inputs are not handled. The bench drives only 0/1.

## Timing
- Reset values: `busy=0`, `done=0`, `pass=0`, `sig_match=0`, `err_count=0`, `first_err_idx=8'hFF`, `signature=MISR_SEED`; state IDLE.
- `rst` mid-session aborts immediately to the reset values. No partial result is reported.
- `start` sampled at edge t: `busy=1` from t.
- A response sampled at edge t updates `err_count`/`signature`/`first_err_idx`, visible after t.
- Last response at edge k:
  - CHECK during cycle k+1.
  - `done=1`, `busy=0`, `pass`/`sig_match` valid after edge k+1.
  - Latency: 2 edges from the last valid to `done`.
- `resp_valid` may be asserted every cycle (no back-pressure) or with arbitrary gaps; gaps do not affect results.
- `done` and results hold stable in DONE indefinitely.

## Structure
- Shared package `bist_pkg`: the FSM state enum {IDLE, RUN, CHECK, DONE}, default MISR width/poly/seed constants, and `ERR_NONE=8'hFF`. The pattern source reuses these.
- One sub-module, `bist_misr`, for reuse on wider CUTs:
  - ports `clk, rst, load, en, seed, din[MISR_W-1:0]`, output `sig`
  - parameterised by MISR_W and MISR_POLY
- Golden model compare and FSM stay inline in the top.

## Test plan
- Fault-free exhaustive: `N_PATTERNS=8`, all 8 `{a,b,cin}` combos with a correct adder; `golden_sig` from the bench MISR model → `err_count=0`, `first_err_idx=FF`, `sig_match=1`, `pass=1`, `done` 2 edges after last valid.
- Sum stuck-at-1: `sum` forced to 1 over 8 patterns → `err_count=4` (patterns 0,3,5,6), `first_err_idx=0`, `pass=0`, signature ≠ fault-free value.
- Cout stuck-at-0 with gaps: `cout` forced to 0, `resp_valid` every other cycle → `err_count=4` (patterns 3,5,6,7), `first_err_idx=3`, results identical to the gapless run.
- Ignored controls: `start` pulsed in mid-RUN and `resp_valid` asserted in IDLE/DONE → no state or counter change; session completes normally.
- Reset mid-run: `rst` high after 3 responses → all outputs return to reset values next edge; a new `start` then gives a full correct session.
- Back-to-back sessions and saturation: second `start` in DONE clears results. Then `N_PATTERNS=255` all-mismatch → `err_count=255` (no wrap), `first_err_idx=0`.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared definitions for the full-adder BIST loop (pattern source and
// response analyzer).
//   bist_state_e  : session FSM states
//   MISR_*_DEF    : default signature width / feedback taps / seed
//   ERR_NONE      : first-failure index value meaning "no failure seen"
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } bist_state_e;

  localparam int unsigned MISR_W_DEF    = 8;
  localparam logic [7:0]  MISR_POLY_DEF = 8'h1D;
  localparam logic [7:0]  MISR_SEED_DEF = 8'h01;
  localparam logic [7:0]  ERR_NONE      = 8'hFF;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register.
//   clk, rst : clock, synchronous active-high reset (loads seed)
//   load     : load seed (session start)
//   en       : compact din into the signature this cycle
//   seed     : value loaded on rst/load
//   din      : parallel response word, XORed in after the shift
//   sig      : current signature
module bist_misr
  import bist_pkg::*;
#(
  parameter int unsigned          MISR_W    = MISR_W_DEF,
  parameter logic [MISR_W-1:0]    MISR_POLY = MISR_W'(MISR_POLY_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [MISR_W-1:0] seed,
  input  logic [MISR_W-1:0] din,
  output logic [MISR_W-1:0] sig
);

  logic [MISR_W-1:0] sig_q;
  logic [MISR_W-1:0] sig_next;

  always_comb begin
    sig_next = {sig_q[MISR_W-2:0], 1'b0} ^ (sig_q[MISR_W-1] ? MISR_POLY : '0) ^ din;
  end

  always_ff @(posedge clk) begin
    if (rst || load) begin
      sig_q <= seed;
    end else if (en) begin
      sig_q <= sig_next;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/bist_response_analyzer.sv
// Output-side analyzer of the 1-bit full-adder BIST loop. Checks each CUT
// response against a golden full-adder, counts mismatches, records the first
// failing pattern index and compacts responses into a MISR signature.
//   clk, rst           : clock, synchronous active-high reset
//   start              : begin a session (honoured in IDLE/DONE only)
//   resp_valid         : a/b/cin/sum/cout valid this cycle (used in RUN only)
//   a, b, cin          : echoed stimulus
//   sum, cout          : CUT response
//   golden_sig         : expected signature, sampled in CHECK
//   busy               : RUN or CHECK
//   done               : session finished, results valid
//   pass, sig_match    : verdicts, valid with done
//   err_count          : mismatching responses, saturates at 255
//   first_err_idx      : index of first mismatch, 8'hFF if none
//   signature          : current/final MISR value
module bist_response_analyzer
  import bist_pkg::*;
#(
  parameter int unsigned       MISR_W     = MISR_W_DEF,
  parameter logic [MISR_W-1:0] MISR_POLY  = MISR_W'(MISR_POLY_DEF),
  parameter logic [MISR_W-1:0] MISR_SEED  = MISR_W'(MISR_SEED_DEF),
  parameter int unsigned       N_PATTERNS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              resp_valid,
  input  logic              a,
  input  logic              b,
  input  logic              cin,
  input  logic              sum,
  input  logic              cout,
  input  logic [MISR_W-1:0] golden_sig,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              sig_match,
  output logic [7:0]        err_count,
  output logic [7:0]        first_err_idx,
  output logic [MISR_W-1:0] signature
);

  bist_state_e state_q, state_d;

  logic [7:0] idx_q;
  logic [7:0] err_q;
  logic [7:0] first_q;
  logic       pass_q;
  logic       match_q;

  logic start_ok;
  logic accept;
  logic last;
  logic exp_sum;
  logic exp_cout;
  logic mismatch;

  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
  assign accept   = resp_valid && (state_q == RUN);
  assign last     = (idx_q == 8'(N_PATTERNS - 1));

  assign exp_sum  = a ^ b ^ cin;
  assign exp_cout = (a & b) | (a & cin) | (b & cin);
  assign mismatch = (sum != exp_sum) || (cout != exp_cout);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (accept && last) state_d = CHECK;
      end
      CHECK: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      idx_q   <= '0;
      err_q   <= '0;
      first_q <= ERR_NONE;
      pass_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      if (accept) begin
        idx_q <= idx_q + 8'd1;
        if (mismatch) begin
          if (err_q != 8'hFF) err_q <= err_q + 8'd1;
          if (first_q == ERR_NONE) first_q <= idx_q;
        end
      end
      // Signature is final while in CHECK: the last response was compacted
      // on the edge that entered CHECK.
      if (state_q == CHECK) begin
        match_q <= (signature == golden_sig);
        pass_q  <= (signature == golden_sig) && (err_q == 8'd0);
      end
    end
  end

  bist_misr #(
    .MISR_W    (MISR_W),
    .MISR_POLY (MISR_POLY)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (start_ok),
    .en   (accept),
    .seed (MISR_SEED),
    .din  ({{(MISR_W-2){1'b0}}, cout, sum}),
    .sig  (signature)
  );

  assign err_count     = err_q;
  assign first_err_idx = first_q;
  assign pass          = pass_q;
  assign sig_match     = match_q;

endmodule

// File: tb/tb_bist_response_analyzer.sv
module tb_bist_response_analyzer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start8, start255, resp_valid;
  logic       a, b, cin, sum, cout;
  logic [7:0] golden8, golden255;

  logic       busy8, done8, pass8, match8;
  logic [7:0] err8, first8, sig8;
  logic       busy255, done255, pass255, match255;
  logic [7:0] err255, first255, sig255;

  int vectors    = 0;
  int miscompares = 0;

  bist_response_analyzer #(
    .MISR_W(8), .MISR_POLY(8'h1D), .MISR_SEED(8'h01), .N_PATTERNS(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start8), .resp_valid(resp_valid),
    .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout), .golden_sig(golden8),
    .busy(busy8), .done(done8), .pass(pass8), .sig_match(match8),
    .err_count(err8), .first_err_idx(first8), .signature(sig8)
  );

  bist_response_analyzer #(
    .MISR_W(8), .MISR_POLY(8'h1D), .MISR_SEED(8'h01), .N_PATTERNS(255)
  ) dut_sat (
    .clk(clk), .rst(rst), .start(start255), .resp_valid(resp_valid),
    .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout), .golden_sig(golden255),
    .busy(busy255), .done(done255), .pass(pass255), .sig_match(match255),
    .err_count(err255), .first_err_idx(first255), .signature(sig255)
  );

  // Reference MISR: multiply by x modulo the feedback polynomial, then add
  // the response word {cout,sum}.
  function automatic logic [7:0] misr_ref(input logic [7:0] s, input int sm, input int co);
    int t;
    t = int'(s) * 2;
    if (t >= 256) t = (t - 256) ^ 'h1D;
    t = t ^ (co * 2 + sm);
    return 8'(t);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},  32'(busy8),  0);
    chk({tag, "_done"},  32'(done8),  0);
    chk({tag, "_pass"},  32'(pass8),  0);
    chk({tag, "_match"}, 32'(match8), 0);
    chk({tag, "_err"},   32'(err8),   0);
    chk({tag, "_first"}, 32'(first8), 32'hFF);
    chk({tag, "_sig"},   32'(sig8),   32'h01);
    chk({tag, "_sat_busy"}, 32'(busy255), 0);
    chk({tag, "_sat_sig"},  32'(sig255),  32'h01);
  endtask

  task automatic drive(input int pat, input int s, input int co, input bit st8);
    @(negedge clk);
    a = pat[2]; b = pat[1]; cin = pat[0];
    sum = s[0]; cout = co[0];
    resp_valid = 1'b1;
    start8 = st8;
    @(posedge clk);
    #1;
    resp_valid = 1'b0;
    start8 = 1'b0;
  endtask

  // mode: 0 fault-free, 1 sum stuck-at-1, 2 cout stuck-at-0,
  //       3 sum inverted on every pattern, 4 random bit flips
  task automatic session(input bit sel, input int n, input int mode, input int gaps,
                         input bit rnd, input bit mid_start, output logic [7:0] sig_out);
    logic [7:0] ms, fs, ferr, ffirst;
    int pat, tot, es, ec, s, co;
    ms = 8'h01; fs = 8'h01; ferr = 0; ffirst = 8'hFF;
    @(negedge clk);
    if (sel) start255 = 1'b1; else start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0; start255 = 1'b0;
    chk("start_busy",  32'(sel ? busy255 : busy8), 1);
    chk("start_done",  32'(sel ? done255 : done8), 0);
    chk("start_pass",  32'(sel ? pass255 : pass8), 0);
    chk("start_err",   32'(sel ? err255 : err8), 0);
    chk("start_first", 32'(sel ? first255 : first8), 32'hFF);
    chk("start_sig",   32'(sel ? sig255 : sig8), 32'h01);
    for (int i = 0; i < n; i++) begin
      pat = rnd ? int'($urandom_range(0, 7)) : (i % 8);
      tot = pat[2] + pat[1] + pat[0];
      es = tot % 2; ec = tot / 2;
      s = es; co = ec;
      case (mode)
        1: s = 1;
        2: co = 0;
        3: s = 1 - es;
        4: begin
          if ($urandom_range(0, 3) == 0) s = 1 - s;
          if ($urandom_range(0, 3) == 0) co = 1 - co;
        end
        default: ;
      endcase
      if (s != es || co != ec) begin
        if (ferr != 8'hFF) ferr = ferr + 1;
        if (ffirst == 8'hFF) ffirst = 8'(i);
      end
      ms = misr_ref(ms, s, co);
      fs = misr_ref(fs, es, ec);
      drive(pat, s, co, mid_start && (i == 3));
      if (!sel) begin
        chk("run_err",   32'(err8), 32'(ferr));
        chk("run_first", 32'(first8), 32'(ffirst));
        chk("run_sig",   32'(sig8), 32'(ms));
      end
      if (i != n - 1) begin
        for (int g = 0; g < gaps; g++) begin
          @(negedge clk);
          {a, b, cin, sum, cout} = 5'($urandom);
          @(posedge clk);
        end
      end
    end
    chk("check_busy", 32'(sel ? busy255 : busy8), 1);
    chk("check_done", 32'(sel ? done255 : done8), 0);
    if (sel) golden255 = fs; else golden8 = fs;
    @(posedge clk);
    #1;
    chk("done_done",  32'(sel ? done255 : done8), 1);
    chk("done_busy",  32'(sel ? busy255 : busy8), 0);
    chk("done_match", 32'(sel ? match255 : match8), 32'(ms == fs));
    chk("done_pass",  32'(sel ? pass255 : pass8), 32'(ms == fs && ferr == 0));
    chk("done_err",   32'(sel ? err255 : err8), 32'(ferr));
    chk("done_first", 32'(sel ? first255 : first8), 32'(ffirst));
    chk("done_sig",   32'(sel ? sig255 : sig8), 32'(ms));
    sig_out = ms;
  endtask

  initial begin
    logic [7:0] ffsig, s1sig, c0sig, tmp;
    rst = 1'b1; start8 = 0; start255 = 0; resp_valid = 0;
    a = 0; b = 0; cin = 0; sum = 0; cout = 0;
    golden8 = 0; golden255 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    // responses while idle are ignored
    for (int i = 0; i < 3; i++) drive(i, 1, 1, 1'b0);
    chk("idle_busy", 32'(busy8), 0);
    chk("idle_err",  32'(err8), 0);
    chk("idle_sig",  32'(sig8), 32'h01);

    // fault-free exhaustive session
    session(1'b0, 8, 0, 0, 1'b0, 1'b0, ffsig);
    chk("ff_pass_const", 32'(pass8), 1);

    // responses while done are ignored, results hold
    for (int i = 0; i < 3; i++) drive(i, 1, 1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("donehold_done", 32'(done8), 1);
    chk("donehold_pass", 32'(pass8), 1);
    chk("donehold_err",  32'(err8), 0);
    chk("donehold_sig",  32'(sig8), 32'(ffsig));

    // sum stuck-at-1 (back-to-back start from DONE)
    session(1'b0, 8, 1, 0, 1'b0, 1'b0, s1sig);
    chk("sa1_err_const",   32'(err8), 4);
    chk("sa1_first_const", 32'(first8), 0);
    chk("sa1_sig_differs", 32'(sig8 != ffsig), 1);

    // cout stuck-at-0, gapless then with gaps
    session(1'b0, 8, 2, 0, 1'b0, 1'b0, c0sig);
    chk("sa0_err_const",   32'(err8), 4);
    chk("sa0_first_const", 32'(first8), 3);
    session(1'b0, 8, 2, 1, 1'b0, 1'b0, tmp);
    chk("gap_sig_same", 32'(sig8), 32'(c0sig));
    chk("gap_err_same", 32'(err8), 4);
    chk("gap_first_same", 32'(first8), 3);

    // start pulsed mid-run is ignored
    session(1'b0, 8, 0, 0, 1'b1, 1'b1, tmp);

    // reset mid-run
    @(negedge clk); start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    for (int i = 0; i < 3; i++) drive(i, 1, 0, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("midrst");
    @(negedge clk); rst = 1'b0;
    session(1'b0, 8, 0, 0, 1'b1, 1'b0, tmp);

    // randomized faults and gaps
    for (int k = 0; k < 4; k++)
      session(1'b0, 8, 4, int'($urandom_range(0, 2)), 1'b1, 1'b0, tmp);

    // 255-pattern all-mismatch session
    session(1'b1, 255, 3, 0, 1'b1, 1'b0, tmp);
    chk("sat_err_const",   32'(err255), 255);
    chk("sat_first_const", 32'(first255), 0);
    chk("sat_pass_const",  32'(pass255), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
